// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and a future transmitter.
//   - rx_state_e     : receiver FSM state encoding
//   - calc_baud_cnt  : sys_clk cycles per bit (integer division)
//   - DEF_CLK_FREQ / DEF_BAUD : default clock and line rate
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  // ST_PARITY is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  function automatic int calc_baud_cnt(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer and falling-edge detector for the rx pin.
//   sys_clk  in  : system clock
//   sys_rst  in  : synchronous active-high reset
//   rx       in  : asynchronous serial line (idles high)
//   rx_s     out : synchronized line
//   rx_fall  out : one-cycle pulse on a 1->0 transition of rx_s, only once
//                  the line has genuinely been seen high since reset
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic       ff1, ff2, prev;
  logic [1:0] vld_pipe;  // tracks when ff1/ff2 hold pin samples rather than reset values
  logic       armed;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ff1      <= 1'b1;
      ff2      <= 1'b1;
      prev     <= 1'b1;
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      ff1      <= rx;
      ff2      <= ff1;
      prev     <= ff2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      // The reset value of the FFs must not count as "seen high", otherwise
      // a line held low through reset would look like a start bit.
      if (vld_pipe[1] && ff2) armed <= 1'b1;
    end
  end

  assign rx_s    = ff2;
  assign rx_fall = armed & prev & ~ff2;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: serial-to-byte receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN).
//   CLK_FREQ, BAUD : sys_clk frequency (Hz) and line rate (bit/s)
//   sys_clk    in  : system clock, rising edge
//   sys_rst    in  : synchronous active-high reset
//   rx         in  : asynchronous serial input, idles high
//   recv_flag  out : one-cycle strobe, byte accepted
//   recv_data  out : last accepted byte, held until the next accept
//   frame_err  out : one-cycle strobe, stop bit sampled low
//   parity_err out : one-cycle strobe, parity mismatch (0 without parity)
//   busy       out : FSM not in IDLE
// Optional feature macro: UART_RX_PARITY_EN (even parity bit before stop).
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic       recv_flag,
  output logic [7:0] recv_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BAUD_CNT_MAX = calc_baud_cnt(CLK_FREQ, BAUD);
  localparam int BAUD_MID     = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_MID);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  logic             rx_s, rx_fall;
  rx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             mid;

  uart_rx_sync u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign mid  = (baud_cnt == CNT_MID);
  assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad, parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      recv_flag <= 1'b0;
      recv_data <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      recv_flag <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      // Counter sits at 0 while waiting, so a start edge begins a bit at 0
      // and every sample point lands at BAUD_MID of its bit.
      if (state == ST_IDLE || state == ST_BREAK) baud_cnt <= '0;
      else if (baud_cnt == CNT_LAST)             baud_cnt <= '0;
      else                                       baud_cnt <= baud_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state <= ST_START;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (mid) begin
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;  // glitch, not a real start bit
            end
          end
        end
        ST_DATA: begin
          if (mid) begin
            shift   <= {rx_s, shift[7:1]};  // LSB first
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (mid) begin
            par_bad <= rx_s ^ (^shift);
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (mid) begin
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err_q <= 1'b1;
              state        <= ST_IDLE;
`endif
            end else begin
              recv_flag <= 1'b1;
              recv_data <= shift;
              state     <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          // Stay here until the line recovers so a held-low line
          // cannot be reframed as a stream of zero bytes.
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

  localparam int BIT = 434;  // 50 MHz / 115200
  localparam int MID = 217;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 3 + 9 * BIT + MID + (PAR_EN ? BIT : 0);

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx      = 1'b0;
  logic       recv_flag, frame_err, parity_err, busy;
  logic [7:0] recv_data;

  uart_byte_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx         (rx),
    .recv_flag  (recv_flag),
    .recv_data  (recv_data),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_bad = 0;

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   n_flag = 0, n_ferr = 0, n_perr = 0, n_busy = 0, n_multi = 0, n_wide = 0;
  int   last_flag_cyc = 0;
  logic [7:0] last_flag_data = 8'h00;
  logic busy_after_flag = 1'b0;
  logic flag_pend = 1'b0;
  logic pf = 1'b0, pfe = 1'b0, ppe = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (flag_pend) begin busy_after_flag = busy; flag_pend = 1'b0; end
    if (recv_flag) begin
      n_flag++; last_flag_cyc = cyc; last_flag_data = recv_data; flag_pend = 1'b1;
    end
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if (busy)       n_busy++;
    if (int'(recv_flag) + int'(frame_err) + int'(parity_err) > 1) n_multi++;
    if ((recv_flag && pf) || (frame_err && pfe) || (parity_err && ppe)) n_wide++;
    pf = recv_flag; pfe = frame_err; ppe = parity_err;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Reference model: 0 = byte accepted, 1 = framing error, 2 = parity error.
  function automatic int model_kind(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) return 1;
    if (PAR_EN && (par != ^d)) return 2;
    return 0;
  endfunction

  logic [7:0] exp_data = 8'h00;
  int         fall_cyc = 0;

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0; fall_cyc = cyc + 1; tick(BIT);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(BIT); end
    if (PAR_EN) begin rx = par; tick(BIT); end
    rx = stop; tick(BIT);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                           input logic stop, input int hold_bits);
    int f0, e0, p0, k;
    f0 = n_flag; e0 = n_ferr; p0 = n_perr;
    k = model_kind(d, par, stop);
    send_frame(d, par, stop);
    if (!stop) begin
      tick(hold_bits * BIT);
      chk({tag, "_break_busy"}, int'(busy), 1);
      rx = 1'b1;
      tick(20);
    end
    if (k == 0) exp_data = d;
    chk({tag, "_flag"}, n_flag - f0, (k == 0) ? 1 : 0);
    chk({tag, "_ferr"}, n_ferr - e0, (k == 1) ? 1 : 0);
    chk({tag, "_perr"}, n_perr - p0, (k == 2) ? 1 : 0);
    chk({tag, "_data"}, int'(recv_data), int'(exp_data));
    if (k == 0) begin
      chk({tag, "_strobe_data"}, int'(last_flag_data), int'(d));
      chk({tag, "_latency"}, int'((last_flag_cyc - fall_cyc <= LAT + 1) &&
                                  (last_flag_cyc - fall_cyc >= LAT - 1)), 1);
      chk({tag, "_busy_drop"}, int'(busy_after_flag), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0, e0, p0, b0;
    logic [7:0] d;
    logic par, stop;

    // Reset with the line held low: outputs at reset values, no start seen.
    tick(5);
    chk("rst_flag", int'(recv_flag), 0);
    chk("rst_data", int'(recv_data), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_perr", int'(parity_err), 0);
    chk("rst_busy", int'(busy), 0);
    sys_rst = 1'b0;
    b0 = n_busy; f0 = n_flag;
    tick(600);
    chk("low_thru_rst_busy", n_busy - b0, 0);
    chk("low_thru_rst_flag", n_flag - f0, 0);
    rx = 1'b1;
    tick(50);

    // Single byte and back-to-back frames.
    run_frame("a5", 8'hA5, ^8'hA5, 1'b1, 0);
    run_frame("b2b_00", 8'h00, 1'b0, 1'b1, 0);
    run_frame("b2b_ff", 8'hFF, 1'b0, 1'b1, 0);
    tick(30);

    // Glitch shorter than half a bit.
    f0 = n_flag; e0 = n_ferr; b0 = n_busy;
    rx = 1'b0; tick(100); rx = 1'b1; tick(600);
    chk("glitch_flag", n_flag - f0, 0);
    chk("glitch_ferr", n_ferr - e0, 0);
    chk("glitch_busy_seen", int'(n_busy - b0 > 0), 1);
    chk("glitch_busy_len", int'(n_busy - b0 <= MID + 3), 1);
    chk("glitch_idle", int'(busy), 0);

    // Framing error, line held low as a break, then recovery.
    run_frame("ferr_3c", 8'h3C, ^8'h3C, 1'b0, 2);
    run_frame("after_break_55", 8'h55, ^8'h55, 1'b1, 0);
    tick(30);

    // Reset pulse during bit 3 of 0x12.
    f0 = n_flag; e0 = n_ferr; p0 = n_perr;
    d = 8'h12;
    rx = 1'b0; tick(BIT);
    for (int i = 0; i < 3; i++) begin rx = d[i]; tick(BIT); end
    rx = d[3]; tick(BIT / 2);
    chk("pre_rst_busy", int'(busy), 1);
    sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
    exp_data = 8'h00;
    chk("midrst_flag", int'(recv_flag), 0);
    chk("midrst_data", int'(recv_data), 0);
    chk("midrst_ferr", int'(frame_err), 0);
    chk("midrst_perr", int'(parity_err), 0);
    chk("midrst_busy", int'(busy), 0);
    rx = 1'b1; tick(2 * BIT);
    chk("midrst_no_flag", n_flag - f0, 0);
    chk("midrst_no_err", (n_ferr - e0) + (n_perr - p0), 0);
    chk("midrst_still_idle", int'(busy), 0);
    run_frame("after_rst_34", 8'h34, ^8'h34, 1'b1, 0);
    tick(30);

`ifdef UART_RX_PARITY_EN
    run_frame("par_ok_07", 8'h07, 1'b1, 1'b1, 0);
    tick(30);
    run_frame("par_bad_07", 8'h07, 1'b0, 1'b1, 0);
    tick(30);
`endif

    // Randomized frames against the model.
    for (int n = 0; n < 5; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", n), d, par, stop, int'($urandom_range(0, 1)));
      tick(int'($urandom_range(0, 40)));
    end

    chk("strobe_exclusive", n_multi, 0);
    chk("strobe_width", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

- Serial-to-byte receiver that feeds the picture-streaming path.
- Samples the asynchronous `rx` line and frames 8N1 characters, optionally with an even-parity bit.
- Presents each accepted byte as `recv_data` with a single-cycle `recv_flag` strobe. This is the same strobe/byte pair the LCD picture writer consumes, so those ports connect to it directly.
- Sits between the board UART pin and the display pipeline. Runs entirely on `sys_clk`.

## Interface
- `CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `sys_clk` in 1: system clock. All logic is on the rising edge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input. Idles high.
- `recv_flag` out 1: one-cycle strobe, byte accepted.
- `recv_data` out 8: last accepted byte. Held until the next accept.
- `frame_err` out 1: one-cycle strobe, stop bit sampled low.
- `parity_err` out 1: one-cycle strobe, parity mismatch. Tied 0 when parity is compiled out.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Input sync:** `rx` passes through a 2-FF synchronizer. Both FFs reset to 1.
- **Start detect:** a falling edge is detected on the synchronized line (previous 1, current 0).
- **Baud constants:**
  - `BAUD_CNT_MAX = CLK_FREQ / BAUD`, integer division.
  - `BAUD_MID = BAUD_CNT_MAX / 2`.
  - The baud counter is `$clog2(BAUD_CNT_MAX)` bits wide. It counts 0..BAUD_CNT_MAX-1, then wraps to 0.
- **States:** IDLE, START, DATA, PARITY (only when compiled in), STOP, BREAK.
- **IDLE:** on a falling edge go to START and clear the baud counter.
  - IDLE only arms after the synchronized line has been seen high at least once since reset. A line held low through reset release is not a start.
- **START:** at `BAUD_MID`, sample the line.
  - Low: go to DATA and clear the bit counter.
  - High: false start, return to IDLE. No strobe is asserted.
- **DATA:** sample each bit at `BAUD_MID`. Data is LSB first and shifts into the shift register.
  - The 3-bit bit counter increments per bit.
  - After bit 7, go to PARITY if compiled in, otherwise STOP.
- **PARITY:** sample at `BAUD_MID`. The expected bit is the XOR of the 8 data bits (even parity). Store the mismatch result and go to STOP.
- **STOP:** sample at `BAUD_MID`.
  - Stop bit = 1, no parity mismatch: `recv_data` <= shift register and `recv_flag` = 1 on the same cycle. Go to IDLE.
  - Stop bit = 1, parity mismatch: `parity_err` = 1. `recv_data` is unchanged and there is no `recv_flag`. Go to IDLE.
  - Stop bit = 0: `frame_err` = 1 (takes priority over a parity error). `recv_data` is unchanged and there is no `recv_flag`. Go to BREAK.
- **BREAK:** wait until the synchronized line is 1, then go to IDLE. This means a break condition never generates spurious frames.
- **Post-frame:** a falling edge during the second half of the stop bit is accepted as the next start once back in IDLE.
- **Reset mid-frame:**
  - Next cycle: state IDLE, all counters 0, outputs at their reset values.
  - A partial frame is discarded.
  - The next frame requires a fresh high-then-low edge.

## Timing
- **Reset values:**
  - `recv_flag` = 0, `recv_data` = 8'h00, `frame_err` = 0, `parity_err` = 0, `busy` = 0.
  - Both synchronizer FFs = 1.
- **Latency:** from the pin falling edge to `recv_flag` is 2 (sync) + 1 (edge) + 9×BAUD_CNT_MAX + BAUD_MID cycles, ±1. Add BAUD_CNT_MAX when parity is enabled.
- **Strobes:**
  - All strobes are exactly 1 cycle and registered.
  - `recv_flag`, `frame_err` and `parity_err` are mutually exclusive within a frame.
  - Minimum spacing between `recv_flag` pulses is 10×BAUD_CNT_MAX − BAUD_MID cycles.
- **Downstream:** no backpressure. The consumer must capture `recv_data` on the strobe or before the next strobe.

## Configuration
- `UART_RX_PARITY_EN`
  - **Defined:** PARITY state exists, frame is 8E1, and `parity_err` is driven.
  - **Undefined:** frame is 8N1, PARITY state is absent, and `parity_err` is constant 0.

## Structure
- **Package `uart_pkg`:** state enum, `calc_baud_cnt(clk, baud)` function, and the default `CLK_FREQ`/`BAUD` constants. The package is shared with a future transmitter.
- **Sub-module `uart_rx_sync`:** 2-FF synchronizer plus falling-edge detector.
  - Outputs `rx_s` and `rx_fall`.
  - Reset-to-1 behavior belongs here.

## Test plan
All scenarios use defaults: `BAUD_CNT_MAX` = 434, `BAUD_MID` = 217.
- **Single byte:** send 8'hA5 as 8N1 → one `recv_flag`, `recv_data` = 8'hA5, `frame_err` = 0, `busy` falls within 1 cycle.
- **Back-to-back:** send 8'h00 then 8'hFF with no idle gap → two `recv_flag` pulses, data 8'h00 then 8'hFF.
- **Glitch:** pulse `rx` low for 100 cycles → no strobe, `busy` returns to 0 before `BAUD_MID` + 3 cycles.
- **Framing error:** send 8'h3C with stop = 0 → `frame_err` pulse, `recv_data` keeps its prior value, no `recv_flag`.
  - Hold `rx` low for 2 more bit times, release it, then send 8'h55 → `recv_flag`, `recv_data` = 8'h55.
- **Reset mid-frame:** pulse `sys_rst` for 1 cycle during bit 3 of 8'h12 → all outputs go to reset values.
  - Next frame 8'h34 → `recv_data` = 8'h34.
- **Parity (`UART_RX_PARITY_EN` defined):**
  - 8'h07 with parity bit 1 → `recv_flag`, `recv_data` = 8'h07.
  - 8'h07 with parity bit 0 → `parity_err` only.
